// File: rtl/mag_pkg.sv
// Shared state codes and default parameters for the microwave cook controller.
package mag_pkg;

  localparam int TIME_W_DEF   = 8;
  localparam int TICK_DIV_DEF = 1000;
  localparam int PWR_W_DEF    = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READY = 3'd1,
    ST_COOK  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/mag_prescaler.sv
// One-second tick generator: counts 0..TICK_DIV-1 while en is high, held at 0 otherwise.
module mag_prescaler
  import mag_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic clk,
  input  logic resetn,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == CNT_W'(TICK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (!en || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mag_cook_ctrl.sv
// Microwave cook controller: load/start/pause/clear FSM, seconds countdown, duty-cycled magnetron.
module mag_cook_ctrl
  import mag_pkg::*;
#(
  parameter int TIME_W   = TIME_W_DEF,
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int PWR_W    = PWR_W_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              startn,
  input  logic              stopn,
  input  logic              clearn,
  input  logic              door_closed,
  input  logic              load,
  input  logic [TIME_W-1:0] time_in,
  input  logic [PWR_W-1:0]  power_in,
  output logic              mag_on,
  output logic              running,
  output logic              done,
  output logic [TIME_W-1:0] time_left,
  output logic [2:0]        state
);

  state_e             state_q, state_d;
  logic [TIME_W-1:0]  time_left_q, time_left_d;
  logic [PWR_W-1:0]   power_q, power_d;
  logic [PWR_W-1:0]   phase_q, phase_d;
  logic               done_q, done_d;
  logic               running_q, running_d;
  logic               tick;
  logic               pause_req;
  logic               start_req;

  mag_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk    (clk),
    .resetn (resetn),
    .en     (state_q == ST_COOK),
    .tick   (tick)
  );

  // Stop/door-open outranks start, so a start press only counts when neither is active.
  assign pause_req = !stopn || !door_closed;
  assign start_req = !startn && door_closed && stopn;

  always_comb begin
    state_d     = state_q;
    time_left_d = time_left_q;
    power_d     = power_q;
    if (!clearn) begin
      state_d     = ST_IDLE;
      time_left_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load && (time_in != '0)) begin
            state_d     = ST_READY;
            time_left_d = time_in;
            power_d     = power_in;
          end
        end
        ST_READY: begin
          if (start_req) begin
            state_d = ST_COOK;
          end else if (load && (time_in != '0)) begin
            time_left_d = time_in;
            power_d     = power_in;
          end
        end
        ST_COOK: begin
          // The final tick finishes the cook even if a pause is requested that cycle.
          if (tick) begin
            if (time_left_q <= TIME_W'(1)) begin
              state_d     = ST_DONE;
              time_left_d = '0;
            end else begin
              time_left_d = time_left_q - 1'b1;
              if (pause_req) begin
                state_d = ST_PAUSE;
              end
            end
          end else if (pause_req) begin
            state_d = ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (start_req) begin
            state_d = ST_COOK;
          end
        end
        ST_DONE: begin
          if (!door_closed) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d     = ST_IDLE;
          time_left_d = '0;
        end
      endcase
    end

    phase_d = '0;
    if ((state_d == ST_COOK) || (state_d == ST_PAUSE)) begin
      phase_d = tick ? phase_q + 1'b1 : phase_q;
    end

    done_d    = (state_d == ST_DONE) && (state_q != ST_DONE);
    running_d = (state_d == ST_COOK);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      time_left_q <= '0;
      power_q     <= '0;
      phase_q     <= '0;
      done_q      <= 1'b0;
      running_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      time_left_q <= time_left_d;
      power_q     <= power_d;
      phase_q     <= phase_d;
      done_q      <= done_d;
      running_q   <= running_d;
    end
  end

  // Door is sampled directly so opening it kills the magnetron without waiting for a clock.
  assign mag_on    = (state_q == ST_COOK) && door_closed && (phase_q <= power_q);
  assign running   = running_q;
  assign done      = done_q;
  assign time_left = time_left_q;
  assign state     = state_q;

endmodule

// File: tb/tb_mag_cook_ctrl.sv
// Directed table-driven bench for mag_cook_ctrl at TIME_W=8, TICK_DIV=4, PWR_W=2.
module tb_mag_cook_ctrl;

  localparam int TIME_W   = 8;
  localparam int TICK_DIV = 4;
  localparam int PWR_W    = 2;

  localparam int S_IDLE  = 0;
  localparam int S_READY = 1;
  localparam int S_COOK  = 2;
  localparam int S_PAUSE = 3;
  localparam int S_DONE  = 4;

  typedef struct {
    logic              clearn;
    logic              startn;
    logic              stopn;
    logic              door;
    logic              load;
    logic [TIME_W-1:0] tin;
    logic [PWR_W-1:0]  pin;
    int                exp_state;
    int                exp_tl;
    int                exp_mag;
    int                exp_done;
  } vec_t;

  logic              clk = 1'b0;
  logic              resetn;
  logic              startn;
  logic              stopn;
  logic              clearn;
  logic              door_closed;
  logic              load;
  logic [TIME_W-1:0] time_in;
  logic [PWR_W-1:0]  power_in;
  logic              mag_on;
  logic              running;
  logic              done;
  logic [TIME_W-1:0] time_left;
  logic [2:0]        state;

  int n_cmp  = 0;
  int n_fail = 0;
  vec_t tbl[$];

  mag_cook_ctrl #(
    .TIME_W   (TIME_W),
    .TICK_DIV (TICK_DIV),
    .PWR_W    (PWR_W)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .startn      (startn),
    .stopn       (stopn),
    .clearn      (clearn),
    .door_closed (door_closed),
    .load        (load),
    .time_in     (time_in),
    .power_in    (power_in),
    .mag_on      (mag_on),
    .running     (running),
    .done        (done),
    .time_left   (time_left),
    .state       (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic add(input logic cl, input logic st, input logic sp, input logic dr,
                     input logic ld, input int tin, input int pin,
                     input int es, input int etl, input int em, input int ed);
    vec_t v;
    v.clearn = cl; v.startn = st; v.stopn = sp; v.door = dr; v.load = ld;
    v.tin = TIME_W'(tin); v.pin = PWR_W'(pin);
    v.exp_state = es; v.exp_tl = etl; v.exp_mag = em; v.exp_done = ed;
    tbl.push_back(v);
  endtask

  task automatic add_idle(input int n, input int es, input int etl, input int em);
    for (int i = 0; i < n; i++) add(1, 1, 1, 1, 0, 0, 0, es, etl, em, 0);
  endtask

  task automatic drive(input logic cl, input logic st, input logic sp, input logic dr,
                       input logic ld, input int tin, input int pin);
    clearn = cl; startn = st; stopn = sp; door_closed = dr; load = ld;
    time_in = TIME_W'(tin); power_in = PWR_W'(pin);
  endtask

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int es, input int etl, input int em, input int ed);
    chk({tag, " state"}, int'(state), es);
    chk({tag, " time_left"}, int'(time_left), etl);
    chk({tag, " mag_on"}, int'(mag_on), em);
    chk({tag, " done"}, int'(done), ed);
    chk({tag, " running"}, int'(running), (es == S_COOK) ? 1 : 0);
  endtask

  initial begin
    int mag_cnt;

    // Normal cook: 3 s at full power.
    add(1, 1, 1, 1, 1, 0, 0, S_IDLE, 0, 0, 0);
    add(1, 1, 1, 1, 1, 3, 3, S_READY, 3, 0, 0);
    add(1, 0, 1, 1, 0, 0, 0, S_COOK, 3, 1, 0);
    add_idle(3, S_COOK, 3, 1);
    add_idle(4, S_COOK, 2, 1);
    add_idle(4, S_COOK, 1, 1);
    add(1, 1, 1, 1, 0, 0, 0, S_DONE, 0, 0, 1);
    add(1, 1, 1, 1, 0, 0, 0, S_DONE, 0, 0, 0);
    add(1, 1, 1, 1, 1, 9, 0, S_DONE, 0, 0, 0);
    add(0, 1, 1, 1, 0, 0, 0, S_IDLE, 0, 0, 0);
    // Door opened at time_left=2, then resumed.
    add(1, 1, 1, 1, 1, 5, 3, S_READY, 5, 0, 0);
    add(1, 0, 1, 1, 0, 0, 0, S_COOK, 5, 1, 0);
    add_idle(3, S_COOK, 5, 1);
    add_idle(4, S_COOK, 4, 1);
    add_idle(4, S_COOK, 3, 1);
    add_idle(2, S_COOK, 2, 1);
    add(1, 1, 1, 0, 0, 0, 0, S_PAUSE, 2, 0, 0);
    add(1, 0, 1, 0, 0, 0, 0, S_PAUSE, 2, 0, 0);
    add(1, 0, 1, 1, 0, 0, 0, S_COOK, 2, 1, 0);
    add_idle(3, S_COOK, 2, 1);
    add_idle(4, S_COOK, 1, 1);
    add(1, 1, 1, 1, 0, 0, 0, S_DONE, 0, 0, 1);
    add(1, 1, 1, 0, 0, 0, 0, S_IDLE, 0, 0, 0);
    // READY with door open, then clear beats start.
    add(1, 1, 1, 1, 1, 7, 1, S_READY, 7, 0, 0);
    add(1, 0, 1, 0, 0, 0, 0, S_READY, 7, 0, 0);
    add(0, 0, 1, 1, 0, 0, 0, S_IDLE, 0, 0, 0);
    // Load ignored while cooking; stop button pauses and outranks start.
    add(1, 1, 1, 1, 1, 6, 3, S_READY, 6, 0, 0);
    add(1, 0, 1, 1, 0, 0, 0, S_COOK, 6, 1, 0);
    add(1, 1, 1, 1, 1, 9, 3, S_COOK, 6, 1, 0);
    add_idle(2, S_COOK, 6, 1);
    add_idle(1, S_COOK, 5, 1);
    add(1, 1, 0, 1, 0, 0, 0, S_PAUSE, 5, 0, 0);
    add(1, 0, 0, 1, 0, 0, 0, S_PAUSE, 5, 0, 0);
    add(1, 0, 1, 1, 0, 0, 0, S_COOK, 5, 1, 0);
    add_idle(2, S_COOK, 5, 1);

    resetn = 1'b0;
    drive(1, 1, 1, 1, 0, 0, 0);
    tick_clk();
    tick_clk();
    chk_all("reset", S_IDLE, 0, 0, 0);
    resetn = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].clearn, tbl[i].startn, tbl[i].stopn, tbl[i].door, tbl[i].load,
            int'(tbl[i].tin), int'(tbl[i].pin));
      tick_clk();
      chk_all($sformatf("vec%0d", i), tbl[i].exp_state, tbl[i].exp_tl,
              tbl[i].exp_mag, tbl[i].exp_done);
    end

    // Reset in the middle of a cook with 5 s left.
    chk("pre-reset time_left", int'(time_left), 5);
    resetn = 1'b0;
    tick_clk();
    chk_all("mid-cook reset", S_IDLE, 0, 0, 0);
    resetn = 1'b1;
    drive(1, 1, 1, 1, 0, 0, 0);

    // Lowest power: magnetron on for the first of every four ticks.
    drive(1, 1, 1, 1, 1, 8, 0);
    tick_clk();
    drive(1, 0, 1, 1, 0, 0, 0);
    tick_clk();
    drive(1, 1, 1, 1, 0, 0, 0);
    mag_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      if (k == 0) chk("p0 first mag", int'(mag_on), 1);
      if (k == 4) chk("p0 off after tick", int'(mag_on), 0);
      mag_cnt += int'(mag_on);
      tick_clk();
    end
    chk("p0 on-count", mag_cnt, 4);
    chk("p0 phase wrap mag", int'(mag_on), 1);
    chk("p0 time_left", int'(time_left), 4);

    // Door opening drops mag_on before the next clock edge.
    drive(0, 1, 1, 1, 0, 0, 0);
    tick_clk();
    drive(1, 1, 1, 1, 1, 3, 3);
    tick_clk();
    drive(1, 0, 1, 1, 0, 0, 0);
    tick_clk();
    drive(1, 1, 1, 1, 0, 0, 0);
    chk("door pre mag", int'(mag_on), 1);
    #2;
    door_closed = 1'b0;
    #1;
    chk("door comb mag", int'(mag_on), 0);
    chk("door comb state", int'(state), S_COOK);
    tick_clk();
    chk_all("door pause", S_PAUSE, 3, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
